// File: rtl/sysid_pkg.sv
// Shared definitions for the extended system-ID slave: word map, CTRL bits
// and the CAPS word layout.
package sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_CAPS      = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd6;
  localparam logic [2:0] ADDR_USER      = 3'd7;

  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;

  typedef struct packed {
    logic [7:0]  rsvd;
    logic [7:0]  rd_latency;
    logic [15:0] version;
  } caps_t;

  function automatic caps_t caps_word(input logic [15:0] version, input logic [7:0] rd_latency);
    caps_t c;
    c.rsvd       = 8'd0;
    c.rd_latency = rd_latency;
    c.version    = version;
    return c;
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Fixed-depth {valid, data} shift register carrying read responses; flushed
// by reset so reads in flight never surface.
module sysid_rd_pipe #(
  parameter int DEPTH = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  output logic        valid,
  output logic [31:0] data
);

  logic [DEPTH-1:0] vld;
  logic [31:0]      dat [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= load;
      // idle slots carry zero so readdata stays 0 outside a valid pulse
      dat[0] <= load ? load_data : 32'd0;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign valid = vld[DEPTH-1];
  assign data  = dat[DEPTH-1];

endmodule

// File: rtl/soc_system_sysid_ext.sv
// Extended system-ID Avalon-MM slave: ID, timestamp, caps, control, 64-bit
// uptime with coherent high-word snapshot, scratch and synchronised user status.
module soc_system_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'h0000_0000,
  parameter logic [15:0] VERSION         = 16'h0002,
  parameter int          READ_LATENCY    = 1,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  input  logic [31:0] user_status
);

  caps_t       caps;
  logic        cnt_en;
  logic        cnt_clr;
  logic        wr_ctrl;
  logic [63:0] uptime;
  logic [63:0] uptime_nxt;
  logic [31:0] uptime_hi_shadow;
  logic [31:0] scratch;
  logic [31:0] user_meta;
  logic [31:0] user_sync;
  logic [31:0] rdata_mux;

  assign caps    = caps_word(VERSION, 8'(READ_LATENCY));
  assign wr_ctrl = write && (address == ADDR_CTRL) && byteenable[0];
  assign cnt_clr = wr_ctrl && writedata[CTRL_CNT_CLR];

  // clear has priority over the increment of the same cycle
  always_comb begin
    uptime_nxt = uptime;
    if (cnt_clr)     uptime_nxt = 64'd0;
    else if (cnt_en) uptime_nxt = uptime + 64'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime <= 64'd0;
      cnt_en <= 1'b1;
    end else begin
      uptime <= uptime_nxt;
      if (wr_ctrl) cnt_en <= writedata[CTRL_CNT_EN];
    end
  end

  // the snapshot uses the pre-clear/pre-increment value seen by the LO read
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 uptime_hi_shadow <= 32'd0;
    else if (read && address == ADDR_UPTIME_LO) uptime_hi_shadow <= uptime[63:32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch <= SCRATCH_RESET;
    end else if (write && address == ADDR_SCRATCH) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) scratch[b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      user_meta <= 32'd0;
      user_sync <= 32'd0;
    end else begin
      user_meta <= user_status;
      user_sync <= user_meta;
    end
  end

  always_comb begin
    rdata_mux = 32'd0;
    case (address)
      ADDR_ID:        rdata_mux = SYSID_ID;
      ADDR_TIMESTAMP: rdata_mux = SYSID_TIMESTAMP;
      ADDR_CAPS:      rdata_mux = caps;
      ADDR_CTRL:      rdata_mux = 32'(cnt_en);
      ADDR_UPTIME_LO: rdata_mux = uptime[31:0];
      ADDR_UPTIME_HI: rdata_mux = uptime_hi_shadow;
      ADDR_SCRATCH:   rdata_mux = scratch;
      ADDR_USER:      rdata_mux = user_sync;
      default:        rdata_mux = 32'd0;
    endcase
  end

  sysid_rd_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .load      (read),
    .load_data (rdata_mux),
    .valid     (readdatavalid),
    .data      (readdata)
  );

endmodule
